shift_seq_ctrl: RTL and testbench

// - Sequences a DEPTH-stage serial shift chain with clk, clr, in and stage enable.
// - Accepts a WIDTH-bit parallel word over a valid/ready handshake.
// - Drives the word MSB-first onto the chain input, one bit per bit period.
// - Appends DEPTH zero "flush" bits so the last data bit reaches the chain output, then pulses done.

---
 rtl/shift_seq_ctrl_pkg.sv | 18 +
 rtl/shift_seq_ctrl_if.sv | 11 +
 rtl/shift_seq_ctrl_bit_tick_gen.sv | 40 ++++
 rtl/shift_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift-chain sequencer: FSM state codes and
// a counter-width helper.
package shift_seq_ctrl_pkg;

  // 3-bit state codes; codes 4..7 are illegal and recover to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3
  } state_e;

  // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Parallel-word valid/ready handshake into the shift sequencer.
interface shift_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/shift_seq_ctrl_bit_tick_gen.sv
// Bit-period divider: emits one tick every DIV clocks while run is high;
// the count is held at zero whenever run is low.
module bit_tick_gen
  import shift_seq_ctrl_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int unsigned   DW       = cnt_w(DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;

  assign tick = run && (div_cnt_q == DIV_LAST);

  // Next divider count: clear when idle or at the end of a bit period.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!run || (div_cnt_q == DIV_LAST)) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // Divider count register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serial shift-chain sequencer: accepts a parallel word, drives it MSB-first
// onto the chain input with one shift strobe per bit period, appends DEPTH
// zero flush bits, then pulses done.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIV   = 1
) (
  input  logic                   clk,
  input  logic                   clr,
  shift_seq_ctrl_if.slave        in_if,
  input  logic                   abort,
  output logic                   ser_out,
  output logic                   shift_en,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned   BW         = cnt_w(WIDTH);
  localparam int unsigned   FW         = cnt_w(DEPTH + 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'((DEPTH == 0) ? 0 : DEPTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  // Goes high on the first edge after reset release; keeps in_ready low
  // until then without a combinational path from clr.
  logic             armed_q;
  logic             run;
  logic             tick;

  // Abort suppresses the tick and clears the divider in the same cycle.
  assign run      = ((state_q == ST_SHIFT) || (state_q == ST_FLUSH)) && !abort;
  assign shift_en = tick;

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .clr  (clr),
    .run  (run),
    .tick (tick)
  );

  // Next-state, datapath updates and per-state outputs.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    bit_cnt_d      = bit_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    ser_out        = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    in_if.in_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_if.in_ready = armed_q;
        if (armed_q && in_if.in_valid && !abort) begin
          shreg_d   = in_if.in_data;
          bit_cnt_d = BIT_LAST;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy    = 1'b1;
        ser_out = shreg_q[WIDTH-1];
        if (abort) begin
          shreg_d     = '0;
          bit_cnt_d   = '0;
          flush_cnt_d = '0;
          state_d     = ST_IDLE;
        end else if (tick) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          if (bit_cnt_q == '0) begin
            if (DEPTH == 0) begin
              state_d = ST_DONE;
            end else begin
              flush_cnt_d = FLUSH_INIT;
              state_d     = ST_FLUSH;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (abort) begin
          shreg_d     = '0;
          bit_cnt_d   = '0;
          flush_cnt_d = '0;
          state_d     = ST_IDLE;
        end else if (tick) begin
          if (flush_cnt_q == '0) begin
            state_d = ST_DONE;
          end else begin
            flush_cnt_d = flush_cnt_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, shift register, counters and reset-release arming flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      flush_cnt_q <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      armed_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: three configurations (DEPTH=4/DIV=1,
// DEPTH=4/DIV=3, DEPTH=0/DIV=1), each feeding a 4-stage (or no) shift chain.
// Stimulus pushes expected strobes and completions into queues; a monitor
// pops and compares them as the DUTs present shift_en and done.
module tb_shift_seq_ctrl;

  typedef struct packed {
    logic ser;
    logic use_chain;
    logic chain;
  } strobe_t;

  typedef struct packed {
    int unsigned done_cyc;
    int unsigned busy_cyc;
  } fin_t;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic       valid_v [3];
  logic [7:0] data_v  [3];
  logic       abort_v [3];
  logic       ready_w [3];
  logic       ser_w   [3];
  logic       sen_w   [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic       chain_w [3];

  shift_seq_ctrl_if #(.WIDTH(8)) if_a ();
  shift_seq_ctrl_if #(.WIDTH(8)) if_b ();
  shift_seq_ctrl_if #(.WIDTH(8)) if_c ();

  assign if_a.in_valid = valid_v[0];
  assign if_a.in_data  = data_v[0];
  assign ready_w[0]    = if_a.in_ready;
  assign if_b.in_valid = valid_v[1];
  assign if_b.in_data  = data_v[1];
  assign ready_w[1]    = if_b.in_ready;
  assign if_c.in_valid = valid_v[2];
  assign if_c.in_data  = data_v[2];
  assign ready_w[2]    = if_c.in_ready;

  shift_seq_ctrl #(.WIDTH(8), .DEPTH(4), .DIV(1)) dut_a (
    .clk(clk), .clr(clr), .in_if(if_a), .abort(abort_v[0]),
    .ser_out(ser_w[0]), .shift_en(sen_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  shift_seq_ctrl #(.WIDTH(8), .DEPTH(4), .DIV(3)) dut_b (
    .clk(clk), .clr(clr), .in_if(if_b), .abort(abort_v[1]),
    .ser_out(ser_w[1]), .shift_en(sen_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  shift_seq_ctrl #(.WIDTH(8), .DEPTH(0), .DIV(1)) dut_c (
    .clk(clk), .clr(clr), .in_if(if_c), .abort(abort_v[2]),
    .ser_out(ser_w[2]), .shift_en(sen_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );

  // Downstream chains: stage 0 takes ser_out on each shift_en.
  logic [3:0] chain_a, chain_b;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      chain_a <= '0;
      chain_b <= '0;
    end else begin
      if (sen_w[0]) chain_a <= {chain_a[2:0], ser_w[0]};
      if (sen_w[1]) chain_b <= {chain_b[2:0], ser_w[1]};
    end
  end
  assign chain_w[0] = chain_a[3];
  assign chain_w[1] = chain_b[3];
  assign chain_w[2] = 1'b0;

  int          checks = 0;
  int          errors = 0;
  strobe_t     q_strobe [3][$];
  fin_t        q_fin    [3][$];
  logic [3:0]  shadow   [3];
  int unsigned cyc      [3];
  int unsigned busy_cnt [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the strobes of one word (data bits then flush zeros) and, when
  // done_cyc is nonzero, its completion cycle and busy length.
  task automatic expect_word(input int k, input logic [7:0] w, input int unsigned n_strobes,
                             input bit use_chain, input int unsigned done_cyc,
                             input int unsigned busy_cyc);
    for (int unsigned i = 0; i < n_strobes; i++) begin
      strobe_t e;
      logic    b;
      b           = (i < 8) ? w[7-i] : 1'b0;
      e.ser       = b;
      e.use_chain = use_chain;
      e.chain     = shadow[k][3];
      shadow[k]   = {shadow[k][2:0], b};
      q_strobe[k].push_back(e);
    end
    if (done_cyc != 0) begin
      fin_t f;
      f.done_cyc = done_cyc;
      f.busy_cyc = busy_cyc;
      q_fin[k].push_back(f);
    end
  endtask

  task automatic monitor_step();
    strobe_t e;
    fin_t    f;
    for (int k = 0; k < 3; k++) begin
      cyc[k]++;
      if (busy_w[k]) busy_cnt[k]++;
      if (sen_w[k]) begin
        check($sformatf("strobe_expected[%0d]", k), 32'(q_strobe[k].size() != 0), 32'd1);
        if (q_strobe[k].size() != 0) begin
          e = q_strobe[k].pop_front();
          check($sformatf("ser_out[%0d]", k), 32'(ser_w[k]), 32'(e.ser));
          if (e.use_chain) check($sformatf("chain_out[%0d]", k), 32'(chain_w[k]), 32'(e.chain));
        end
      end
      if (done_w[k]) begin
        check($sformatf("done_expected[%0d]", k), 32'(q_fin[k].size() != 0), 32'd1);
        if (q_fin[k].size() != 0) begin
          f = q_fin[k].pop_front();
          check($sformatf("done_cycle[%0d]", k), cyc[k], f.done_cyc);
          check($sformatf("busy_cycles[%0d]", k), busy_cnt[k], f.busy_cyc);
          check($sformatf("ser_out_in_done[%0d]", k), 32'(ser_w[k]), 32'd0);
        end
      end
      if (valid_v[k] && ready_w[k] && !abort_v[k]) begin
        cyc[k]      = 0;
        busy_cnt[k] = 0;
      end
    end
  endtask

  // Offer a word at posedge+1; return at posedge+1 after the accepting edge.
  task automatic offer(input int k, input logic [7:0] w, input string name);
    int unsigned n = 0;
    valid_v[k] = 1'b1;
    data_v[k]  = w;
    do begin
      @(negedge clk);
      n++;
    end while (!(ready_w[k] && !abort_v[k]) && n < 40);
    check(name, 32'(ready_w[k]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for done; returns at the negedge where done is seen.
  task automatic wait_done(input int k, input int unsigned budget, input string name);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_w[k] && n < budget);
    check(name, 32'(done_w[k]), 32'd1);
  endtask

  task automatic stimulus();
    // Reset held with in_valid high: everything quiet.
    #3;
    check("rst_in_ready", 32'(ready_w[0]), 32'd0);
    check("rst_ser_out", 32'(ser_w[0]), 32'd0);
    check("rst_busy", 32'(busy_w[0]), 32'd0);
    check("rst_shift_en", 32'(sen_w[0]), 32'd0);
    check("rst_done", 32'(done_w[0]), 32'd0);
    #19;
    for (int k = 0; k < 3; k++) valid_v[k] = 1'b0;
    clr = 1'b1;
    #1;
    check("release_cycle_in_ready", 32'(ready_w[0]), 32'd0);
    @(posedge clk);
    #1;
    check("first_cycle_in_ready", 32'(ready_w[0]), 32'd1);

    // A5 through DEPTH=4, DIV=1; in_data changes after accept and is ignored.
    expect_word(0, 8'hA5, 12, 1'b1, 13, 12);
    offer(0, 8'hA5, "accept_a5");
    valid_v[0] = 1'b0;
    data_v[0]  = 8'h5A;
    wait_done(0, 30, "done_a5");
    @(posedge clk); #1;

    // 81 with DIV=3.
    expect_word(1, 8'h81, 12, 1'b1, 37, 36);
    offer(1, 8'h81, "accept_81");
    valid_v[1] = 1'b0;
    wait_done(1, 60, "done_81");
    @(posedge clk); #1;

    // Back-to-back FF then 00 with in_valid held high.
    expect_word(0, 8'hFF, 12, 1'b1, 13, 12);
    expect_word(0, 8'h00, 12, 1'b1, 13, 12);
    offer(0, 8'hFF, "accept_ff");
    data_v[0] = 8'h00;
    wait_done(0, 30, "done_ff");
    check("ready_in_done", 32'(ready_w[0]), 32'd0);
    @(negedge clk);
    check("b2b_accept_after_done", 32'(ready_w[0] && valid_v[0]), 32'd1);
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    wait_done(0, 30, "done_00");
    @(posedge clk); #1;

    // Abort on the 5th strobe of C3, then a fresh word.
    expect_word(0, 8'hC3, 4, 1'b1, 0, 0);
    offer(0, 8'hC3, "accept_c3");
    valid_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    abort_v[0] = 1'b1;
    @(negedge clk);
    check("abort_masks_shift_en", 32'(sen_w[0]), 32'd0);
    @(posedge clk); #1;
    abort_v[0] = 1'b0;
    check("abort_busy_next", 32'(busy_w[0]), 32'd0);
    check("abort_ready_next", 32'(ready_w[0]), 32'd1);
    repeat (15) @(posedge clk);
    #1;
    expect_word(0, 8'h96, 12, 1'b1, 13, 12);
    offer(0, 8'h96, "accept_96");
    valid_v[0] = 1'b0;
    wait_done(0, 30, "done_96");
    @(posedge clk); #1;

    // DEPTH=0: no flush phase.
    expect_word(2, 8'h01, 8, 1'b0, 9, 8);
    offer(2, 8'h01, "accept_01");
    valid_v[2] = 1'b0;
    wait_done(2, 30, "done_01");
    @(posedge clk); #1;

    // clr pulsed low in the second flush cycle of 3C: no done afterwards.
    expect_word(0, 8'h3C, 9, 1'b1, 0, 0);
    offer(0, 8'h3C, "accept_3c");
    valid_v[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    clr = 1'b0;
    for (int k = 0; k < 3; k++) shadow[k] = '0;
    #1;
    check("clr_busy", 32'(busy_w[0]), 32'd0);
    check("clr_shift_en", 32'(sen_w[0]), 32'd0);
    check("clr_ser_out", 32'(ser_w[0]), 32'd0);
    check("clr_ready", 32'(ready_w[0]), 32'd0);
    @(negedge clk);
    #1;
    clr = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("ready_after_clr", 32'(ready_w[0]), 32'd1);

    for (int k = 0; k < 3; k++) begin
      check($sformatf("strobes_left[%0d]", k), q_strobe[k].size(), 32'd0);
      check($sformatf("dones_left[%0d]", k), q_fin[k].size(), 32'd0);
    end
  endtask

  initial begin
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid_v[k]  = 1'b1;
      data_v[k]   = 8'h00;
      abort_v[k]  = 1'b0;
      shadow[k]   = '0;
      cyc[k]      = 0;
      busy_cnt[k] = 0;
    end
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
      stimulus();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
